// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, ALU codes,
// the FSM state type and the opcode-to-ALU mapping.
package ctrl_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP      = 5'd0;
  localparam logic [OPC_W-1:0] OP_MOV_R2RC = 5'd1;
  localparam logic [OPC_W-1:0] OP_MOV_C2RC = 5'd2;
  localparam logic [OPC_W-1:0] OP_MOV_RC2R = 5'd3;
  localparam logic [OPC_W-1:0] OP_MOV_R2RA = 5'd4;
  localparam logic [OPC_W-1:0] OP_LOAD     = 5'd5;
  localparam logic [OPC_W-1:0] OP_STORE    = 5'd6;
  localparam logic [OPC_W-1:0] OP_NOT      = 5'd7;
  localparam logic [OPC_W-1:0] OP_AND      = 5'd8;
  localparam logic [OPC_W-1:0] OP_OR       = 5'd9;
  localparam logic [OPC_W-1:0] OP_XOR      = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADD      = 5'd11;
  localparam logic [OPC_W-1:0] OP_SUB      = 5'd12;
  localparam logic [OPC_W-1:0] OP_INC      = 5'd13;
  localparam logic [OPC_W-1:0] OP_HALT     = 5'd14;
  localparam logic [OPC_W-1:0] OP_JMP      = 5'd15;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_NOT  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_ADD  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_OPND  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } ctrl_state_t;

  function automatic logic [2:0] alu_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOT:  return ALU_NOT;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_INC:  return ALU_INC;
      default: return ALU_NONE;
    endcase
  endfunction

  // Instructions that carry a second (operand) byte.
  function automatic logic has_operand(input logic [OPC_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/program_counter_ld.sv
// Program counter with increment, synchronous load (load wins) and
// asynchronous reset; wraps silently at the top of the address space.
module program_counter_ld #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetches instruction and operand bytes,
// decodes the instruction register into datapath strobes, handles load/store/jump.
//
// Memory handshake: memAddr (and memWe for stores) is presented by the sequencer
// and held stable; the access completes in the cycle memReady is high, and only
// then does the FSM advance. memReady low simply stalls the current state.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int REG_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    memVal,
  input  logic                 memReady,
  output logic [ADDR_W-1:0]    memAddr,
  output logic                 memWe,
  output logic [REG_SEL_W-1:0] regSel,
  output logic [2:0]           aluSel,
  output logic                 Rin,
  output logic                 Rout,
  output logic                 RAin,
  output logic                 RCout,
  output logic                 RCin,
  output logic                 genConst,
  output logic                 halted,
  output logic                 illegal,
  output ctrl_state_t          dbg_state
);

  ctrl_state_t       state, state_nx;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc, pc_ld, ir_ld, addr_ld;
  logic [OPC_W-1:0]  op, fetch_op;

  assign op        = ir[DATA_W-1 -: OPC_W];
  assign fetch_op  = memVal[DATA_W-1 -: OPC_W];
  assign dbg_state = state;

  program_counter_ld #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .ld     (pc_ld),
    .ld_val (memVal[ADDR_W-1:0]),
    .pc     (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      ir       <= '0;
      addr_reg <= '0;
    end else begin
      state <= state_nx;
      if (ir_ld)   ir       <= memVal;
      if (addr_ld) addr_reg <= memVal[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    addr_ld  = 1'b0;
    memAddr  = pc;
    memWe    = 1'b0;
    regSel   = '0;
    aluSel   = ALU_NONE;
    Rin      = 1'b0;
    Rout     = 1'b0;
    RAin     = 1'b0;
    RCout    = 1'b0;
    RCin     = 1'b0;
    genConst = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;

    case (state)
      ST_FETCH: begin
        if (memReady) begin
          ir_ld    = 1'b1;
          pc_inc   = 1'b1;
          state_nx = has_operand(fetch_op) ? ST_OPND : ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Opcodes 16-31 are undefined: flag them and otherwise act as NOP.
        if (op[OPC_W-1]) begin
          illegal = 1'b1;
        end else begin
          regSel = ir[REG_SEL_W-1:0];
          aluSel = alu_of(op);
          case (op)
            OP_MOV_R2RC: Rout = 1'b1;
            OP_MOV_C2RC: genConst = 1'b1;
            OP_MOV_RC2R: begin
              Rin   = 1'b1;
              RCout = 1'b1;
            end
            OP_MOV_R2RA: begin
              Rout = 1'b1;
              RAin = 1'b1;
            end
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_INC: Rout = 1'b1;
            default: ;
          endcase
        end
        state_nx = (op == OP_HALT) ? ST_HALT : ST_FETCH;
      end

      ST_OPND: begin
        if (memReady) begin
          addr_ld = 1'b1;
          if (op == OP_JMP) begin
            pc_ld    = 1'b1;
            state_nx = ST_FETCH;
          end else begin
            pc_inc   = 1'b1;
            state_nx = ST_MEM;
          end
        end
      end

      ST_MEM: begin
        memAddr = addr_reg;
        if (op == OP_LOAD) begin
          RCin = 1'b1;
        end else if (op == OP_STORE) begin
          memWe = 1'b1;
          RCout = 1'b1;
        end
        if (memReady) state_nx = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_nx = ST_FETCH;
    endcase
  end

endmodule
